// File: rtl/uart_tx.sv
// ============================================================================
//  Module   : uart_tx
//  Summary  : Memory-mapped UART transmitter (start, 8 data LSB-first,
//             parity, 1 or 2 stop bits) with a one-byte holding buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [13:0] baud_divisor,
    input  logic [7:0]  raw_data,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        Tx_en,
    input  logic        Two_stop,
    input  logic        Odd_parity,
    output logic [31:0] rdata,
    output logic        Tx_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    localparam logic [3:0] C_OFF_TXDATA = 4'h0;
    localparam logic [3:0] C_OFF_BAUD   = 4'h4;
    localparam logic [3:0] C_OFF_CTRL   = 4'h8;
    localparam logic [3:0] C_OFF_STATUS = 4'hC;

    state_t      state_q,  state_d;
    logic [7:0]  hold_q,   hold_d;
    logic        full_q,   full_d;
    logic [13:0] div_q,    div_d;
    logic        en_q,     en_d;
    logic        two_q,    two_d;
    logic        odd_q,    odd_d;
    logic [7:0]  shift_q,  shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [13:0] cnt_q,    cnt_d;
    logic [13:0] per_q,    per_d;
    logic        par_q,    par_d;
    logic        fr_two_q, fr_two_d;

    logic w_sel;
    logic w_wr_txdata;
    logic w_wr_baud;
    logic w_wr_ctrl;
    logic w_bit_done;
    logic w_load;
    logic w_frame_end;
    logic w_busy;

    assign w_sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_txdata = wr_en && w_sel && (addr[3:0] == C_OFF_TXDATA);
    assign w_wr_baud   = wr_en && w_sel && (addr[3:0] == C_OFF_BAUD);
    assign w_wr_ctrl   = wr_en && w_sel && (addr[3:0] == C_OFF_CTRL);
    assign w_bit_done  = (cnt_q == per_q - 14'd1);
    assign w_busy      = (state_q != S_IDLE);

    // Frame parameters are snapshotted on load so bus writes cannot disturb a frame.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        per_d       = per_q;
        par_d       = par_q;
        fr_two_d    = fr_two_q;
        w_load      = 1'b0;
        w_frame_end = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = w_bit_done ? 14'd0 : cnt_q + 14'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (en_q && full_q) begin
                    w_load = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_done) begin
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_bit_done) begin
                    if (fr_two_q) begin
                        state_d = S_STOP2;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (w_bit_done) begin
                    w_frame_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_frame_end) begin
            if (en_q && full_q) begin
                w_load = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (w_load) begin
            state_d  = S_START;
            cnt_d    = 14'd0;
            shift_d  = hold_q;
            per_d    = (div_q == 14'd0) ? 14'd1 : div_q;
            par_d    = odd_q ? ~^hold_q : ^hold_q;
            fr_two_d = two_q;
        end
    end

    // A write arriving on the same edge the buffer is emptied is kept.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        div_d  = div_q;
        en_d   = en_q;
        two_d  = two_q;
        odd_d  = odd_q;

        if (w_load) begin
            full_d = 1'b0;
        end
        if (w_wr_txdata && (!full_q || w_load)) begin
            hold_d = raw_data;
            full_d = 1'b1;
        end
        if (w_wr_baud) begin
            div_d = baud_divisor;
        end
        if (w_wr_ctrl) begin
            en_d  = Tx_en;
            two_d = Two_stop;
            odd_d = Odd_parity;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hold_q    <= 8'd0;
            full_q    <= 1'b0;
            div_q     <= 14'd0;
            en_q      <= 1'b0;
            two_q     <= 1'b0;
            odd_q     <= 1'b0;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            cnt_q     <= 14'd0;
            per_q     <= 14'd0;
            par_q     <= 1'b0;
            fr_two_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            div_q     <= div_d;
            en_q      <= en_d;
            two_q     <= two_d;
            odd_q     <= odd_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            par_q     <= par_d;
            fr_two_q  <= fr_two_d;
        end
    end

    always_comb begin
        Tx_out = 1'b1;
        case (state_q)
            S_START:  Tx_out = 1'b0;
            S_DATA:   Tx_out = shift_q[bit_idx_q];
            S_PARITY: Tx_out = par_q;
            default:  Tx_out = 1'b1;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        if (rd_en && w_sel) begin
            case (addr[3:0])
                C_OFF_TXDATA: rdata = {24'h0, hold_q};
                C_OFF_BAUD:   rdata = {18'h0, div_q};
                C_OFF_CTRL:   rdata = {29'h0, odd_q, two_q, en_q};
                C_OFF_STATUS: rdata = {30'h0, w_busy, full_q};
                default:      rdata = 32'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module   : tb_uart_tx
//  Summary  : Directed self-checking bench for uart_tx.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_BD = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;
    localparam logic [31:0] A_ST = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [13:0] baud_divisor;
    logic [7:0]  raw_data;
    logic        wr_en;
    logic        rd_en;
    logic        Tx_en;
    logic        Two_stop;
    logic        Odd_parity;
    logic [31:0] rdata;
    logic        Tx_out;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .baud_divisor (baud_divisor),
        .raw_data     (raw_data),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .Tx_en        (Tx_en),
        .Two_stop     (Two_stop),
        .Odd_parity   (Odd_parity),
        .rdata        (rdata),
        .Tx_out       (Tx_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called during the clock's low phase; the write lands on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr         = a;
        raw_data     = d[7:0];
        baud_divisor = d[13:0];
        Tx_en        = d[0];
        Two_stop     = d[1];
        Odd_parity   = d[2];
        wr_en        = 1'b1;
        rd_en        = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr  = a;
        rd_en = 1'b1;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic idle_check(input string tag, input int n, input logic [31:0] exp_status);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            addr  = A_ST;
            rd_en = 1'b1;
            #1;
            check($sformatf("%s_line%0d", tag, i), {31'h0, Tx_out}, 32'h1);
            check($sformatf("%s_status%0d", tag, i), rdata, exp_status);
        end
    endtask

    // bits[k] is the k-th line bit of the frame; writes at index i land on the
    // rising edge just before sample i; full is expected high for fl <= i <= fh.
    task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits,
                               input int p, input int wa1, input logic [7:0] d1,
                               input int wa2, input logic [7:0] d2,
                               input int fl, input int fh);
        for (int i = 0; i < nbits * p; i++) begin
            if (i == wa1 || i == wa2) begin
                addr     = A_TX;
                raw_data = (i == wa1) ? d1 : d2;
                wr_en    = 1'b1;
                rd_en    = 1'b0;
            end
            @(negedge clk);
            wr_en = 1'b0;
            addr  = A_ST;
            rd_en = 1'b1;
            #1;
            check($sformatf("%s_bit%0d", tag, i), {31'h0, Tx_out}, {31'h0, bits[i / p]});
            check($sformatf("%s_stat%0d", tag, i), rdata,
                  {30'h0, 1'b1, (i >= fl && i <= fh)});
        end
    endtask

    initial begin
        reset        = 1'b0;
        addr         = A_ST;
        baud_divisor = 14'd0;
        raw_data     = 8'd0;
        wr_en        = 1'b0;
        rd_en        = 1'b1;
        Tx_en        = 1'b0;
        Two_stop     = 1'b0;
        Odd_parity   = 1'b0;

        // Reset values visible while reset is held
        #2;
        check("rst_line", {31'h0, Tx_out}, 32'h1);
        check("rst_status", rdata, 32'h0);
        addr = A_CT; #1;
        check("rst_ctrl", rdata, 32'h0);
        addr = A_BD; #1;
        check("rst_baud", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle_check("post_rst", 3, 32'h0);

        // Config readback, unmapped read, unselected write
        bus_write(A_BD, 32'd4);
        bus_write(A_CT, 32'h1);
        read_check("rd_baud4", A_BD, 32'd4);
        read_check("rd_ctrl1", A_CT, 32'h1);
        read_check("rd_unmapped", BASE + 32'h6, 32'h0);
        bus_write(32'h9000_0000, 32'h77);
        idle_check("unsel_wr", 2, 32'h0);
        read_check("unsel_buf", A_TX, 32'h0);

        // Even parity, P=4: 0xA5 -> 0,1,0,1,0,0,1,0,1,0,1
        bus_write(A_TX, 32'hA5);
        check_frame("even", 12'hD4A, 11, 4, -1, 8'h0, -1, 8'h0, 1, 0);
        idle_check("even_end", 1, 32'h0);

        // Odd parity, two stop bits, P=2: 0x01 -> parity 0
        bus_write(A_CT, 32'h7);
        bus_write(A_BD, 32'd2);
        read_check("rd_ctrl7", A_CT, 32'h7);
        read_check("rd_baud2", A_BD, 32'd2);
        bus_write(A_TX, 32'h01);
        check_frame("odd2", 12'hC02, 12, 2, -1, 8'h0, -1, 8'h0, 1, 0);
        idle_check("odd2_end", 1, 32'h0);

        // Back-to-back with divisor 0 (P=1); third write while full is dropped
        bus_write(A_BD, 32'd0);
        bus_write(A_CT, 32'h1);
        bus_write(A_TX, 32'h55);
        check_frame("b2b_a", 12'hCAA, 11, 1, 1, 8'hAA, 3, 8'hCC, 1, 10);
        check_frame("b2b_b", 12'hD54, 11, 1, -1, 8'h0, -1, 8'h0, 1, 0);
        idle_check("b2b_end", 2, 32'h0);
        read_check("b2b_buf", A_TX, 32'hAA);

        // Disabled: byte waits; enabling starts next edge; write on the load edge is kept
        bus_write(A_BD, 32'd1);
        bus_write(A_CT, 32'h0);
        bus_write(A_TX, 32'h3C);
        idle_check("dis", 4, 32'h1);
        bus_write(A_CT, 32'h1);
        check_frame("en_a", 12'hC78, 11, 1, 0, 8'h81, -1, 8'h0, 0, 10);
        check_frame("en_b", 12'hD02, 11, 1, -1, 8'h0, -1, 8'h0, 1, 0);
        idle_check("en_end", 1, 32'h0);

        // Mid-frame reset, P=4, 0xF0: after 6 edges the line is low in DATA bit 0
        bus_write(A_BD, 32'd4);
        bus_write(A_TX, 32'hF0);
        repeat (6) @(negedge clk);
        addr  = A_ST;
        rd_en = 1'b1;
        #1;
        check("mid_low", {31'h0, Tx_out}, 32'h0);
        check("mid_busy", rdata, 32'h2);
        reset = 1'b0;
        #1;
        check("mid_rst_line", {31'h0, Tx_out}, 32'h1);
        check("mid_rst_status", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle_check("mid_after", 3, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
